// File: rtl/rom_arbiter.sv
// rom_arbiter
//   Shares one synchronous single-port ROM (1-cycle read latency) among NREQ
//   requesters using round-robin arbitration. It steers the granted address
//   to the ROM and returns the read data to the requester that owns the read.
//   If that owner is not ready for the data, the data is parked in a hold
//   register, so back-to-back reads run at one per cycle while each
//   requester can still stall its own response.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           synchronous reset, active-high
//   i_req_valid   [NREQ]        request valid per requester
//   i_req_addr    [NREQ*abits]  byte address; requester k at [k*abits +: abits]
//   o_req_ready   [NREQ]        one-hot grant (handshake = valid & ready)
//   o_resp_valid  [NREQ]        one-hot response valid (owner of the read)
//   o_resp_data   [dbits]       read data shared by all requesters
//   i_resp_ready  [NREQ]        response accept per requester (owner only)
//   o_rom_addr    [abits]       ROM address; the ROM drops the low byte bits
//   i_rom_data    [dbits]       ROM data, valid one cycle after the address

module rom_arbiter #(
    parameter  int NREQ        = 2,
    parameter  int abits       = 12,
    parameter  int log2_dbytes = 3,
    localparam int DBITS       = 8 * (2 ** log2_dbytes),
    localparam int IW          = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       i_req_valid,
    input  logic [NREQ*abits-1:0] i_req_addr,
    output logic [NREQ-1:0]       o_req_ready,
    output logic [NREQ-1:0]       o_resp_valid,
    output logic [DBITS-1:0]      o_resp_data,
    input  logic [NREQ-1:0]       i_resp_ready,
    output logic [abits-1:0]      o_rom_addr,
    input  logic [DBITS-1:0]      i_rom_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // no outstanding read
        S_RESP = 2'd1,   // ROM data for the previous grant is on i_rom_data
        S_HOLD = 2'd2    // data parked in r_hold awaiting the owner's accept
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IW-1:0]      r_owner;
    logic [IW-1:0]      r_rr_last;
    logic [DBITS-1:0]   r_hold;
    logic [abits-1:0]   r_rom_addr;

    logic               w_owner_ready;
    logic               w_can_grant;
    logic               w_any_valid;
    logic               w_found_hi;
    logic [IW-1:0]      w_idx_hi;
    logic [IW-1:0]      w_idx_lo;
    logic [IW-1:0]      w_gidx;
    logic [abits-1:0]   w_gaddr;
    logic               w_fire;
    logic               w_hold_load;
    logic [31:0]        w_rr_ext;

    // ------------------------------------------------------------------
    // Round-robin pick: the first valid requester strictly above rr_last
    // wins; otherwise wrap around to the lowest valid index. This is the
    // same as searching rr_last+1, rr_last+2, ... modulo NREQ, without
    // needing a modulo for non-power-of-two NREQ.
    // ------------------------------------------------------------------
    always_comb begin
        w_rr_ext    = 32'(r_rr_last);
        w_found_hi  = 1'b0;
        w_any_valid = 1'b0;
        w_idx_hi    = '0;
        w_idx_lo    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (i_req_valid[k] && (k > w_rr_ext) && !w_found_hi) begin
                w_found_hi = 1'b1;
                w_idx_hi   = IW'(k);
            end
            if (i_req_valid[k] && !w_any_valid) begin
                w_any_valid = 1'b1;
                w_idx_lo    = IW'(k);
            end
        end
        w_gidx = w_found_hi ? w_idx_hi : w_idx_lo;
    end

    always_comb begin
        w_gaddr = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (w_gidx == IW'(k)) begin
                w_gaddr = i_req_addr[k*abits +: abits];
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant qualification. A new read may start when nothing is pending or
    // when the current owner takes its data this cycle (from the ROM or
    // from the hold register). Grants are suppressed while rst is high so
    // no handshake is reported for a read that reset will discard.
    // ------------------------------------------------------------------
    always_comb begin
        w_owner_ready = i_resp_ready[r_owner];
        w_can_grant   = !rst && ((r_state == S_IDLE) || w_owner_ready);
        w_fire        = w_can_grant && w_any_valid;
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_hold_load  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fire) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (w_owner_ready) begin
                    w_state_next = w_fire ? S_RESP : S_IDLE;
                end else begin
                    // ROM data is only valid this one cycle: capture it.
                    w_hold_load  = 1'b1;
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_owner_ready) begin
                    w_state_next = w_fire ? S_RESP : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs.
    // ------------------------------------------------------------------
    always_comb begin
        o_req_ready  = w_fire ? (NREQ'(1) << w_gidx) : '0;
        o_resp_valid = '0;
        if (!rst && (r_state != S_IDLE)) begin
            o_resp_valid = NREQ'(1) << r_owner;
        end
        // Outside RESP the hold register is presented; it is zero out of
        // reset, which keeps o_resp_data quiet until the first stall.
        o_resp_data  = (r_state == S_RESP) ? i_rom_data : r_hold;
        // The address goes out combinationally in the grant cycle so the
        // ROM returns data on the next cycle; otherwise hold the last one.
        o_rom_addr   = w_fire ? w_gaddr : r_rom_addr;
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_rr_last  <= IW'(NREQ - 1);
            r_hold     <= '0;
            r_rom_addr <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_fire) begin
                r_owner    <= w_gidx;
                r_rr_last  <= w_gidx;
                r_rom_addr <= w_gaddr;
            end
            if (w_hold_load) begin
                r_hold <= i_rom_data;
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter
//   Directed bench for rom_arbiter with NREQ=2, abits=12, 64-bit data.
//   A behavioural 1-cycle-latency ROM holds word i = A5A5_0000_0000_0000 + i.
//   Inputs are driven 1 time unit after the rising edge and outputs are
//   checked 2 time units later, well before the next edge.

module tb_rom_arbiter;

    localparam int NREQ  = 2;
    localparam int ABITS = 12;
    localparam logic [63:0] BASE = 64'hA5A5_0000_0000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid;
    logic [23:0]       req_addr;
    logic [1:0]        req_ready;
    logic [1:0]        resp_valid;
    logic [63:0]       resp_data;
    logic [1:0]        resp_ready;
    logic [11:0]       rom_addr;
    logic [63:0]       rom_data = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // ROM model: registered read, byte address to word index.
    always @(posedge clk) rom_data <= BASE + 64'(rom_addr[11:3]);

    rom_arbiter #(
        .NREQ        (NREQ),
        .abits       (ABITS),
        .log2_dbytes (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (req_valid),
        .i_req_addr   (req_addr),
        .o_req_ready  (req_ready),
        .o_resp_valid (resp_valid),
        .o_resp_data  (resp_data),
        .i_resp_ready (resp_ready),
        .o_rom_addr   (rom_addr),
        .i_rom_data   (rom_data)
    );

    function automatic logic [63:0] word(input int i);
        return BASE + 64'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        req_valid = 2'b00;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b00; req_addr = '0; resp_ready = 2'b11;
        repeat (3) tick();
        rst = 1'b0;
        #2;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL reset_resp_valid: got %b expected 00", resp_valid); end
        total++; if (resp_data !== 64'h0) begin bad++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
        total++; if (rom_addr !== 12'h000) begin bad++; $display("FAIL reset_rom_addr: got %h expected 000", rom_addr); end
    endtask

    task automatic test_single();
        tick();
        req_valid = 2'b01; req_addr[11:0] = 12'h010; resp_ready = 2'b11;
        #2;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_grant: got %b expected 01", req_ready); end
        total++; if (rom_addr !== 12'h010) begin bad++; $display("FAIL single_rom_addr: got %h expected 010", rom_addr); end
        tick();
        req_valid = 2'b00;
        #2;
        total++; if (resp_valid !== 2'b01) begin bad++; $display("FAIL single_resp_valid: got %b expected 01", resp_valid); end
        total++; if (resp_data !== word(2)) begin bad++; $display("FAIL single_resp_data: got %h expected %h", resp_data, word(2)); end
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL single_no_grant: got %b expected 00", req_ready); end
        tick();
        #2;
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL single_idle: got %b expected 00", resp_valid); end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_g;
        logic [1:0]  prev_g;
        logic [11:0] exp_a;
        do_reset();
        prev_g = 2'b00;
        for (int i = 0; i < 6; i++) begin
            tick();
            req_valid = 2'b11; req_addr = {12'h008, 12'h000}; resp_ready = 2'b11;
            #2;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (i % 2 == 0) ? 12'h000 : 12'h008;
            total++; if (req_ready !== exp_g) begin bad++; $display("FAIL contention_grant[%0d]: got %b expected %b", i, req_ready, exp_g); end
            total++; if (rom_addr !== exp_a) begin bad++; $display("FAIL contention_addr[%0d]: got %h expected %h", i, rom_addr, exp_a); end
            if (i > 0) begin
                total++; if (resp_valid !== prev_g) begin bad++; $display("FAIL contention_resp_valid[%0d]: got %b expected %b", i, resp_valid, prev_g); end
                total++; if (resp_data !== word((i - 1) % 2)) begin bad++; $display("FAIL contention_resp_data[%0d]: got %h expected %h", i, resp_data, word((i - 1) % 2)); end
            end
            prev_g = exp_g;
        end
        tick();
        req_valid = 2'b00;
        #2;
        total++; if (resp_valid !== 2'b10) begin bad++; $display("FAIL contention_last_valid: got %b expected 10", resp_valid); end
        total++; if (resp_data !== word(1)) begin bad++; $display("FAIL contention_last_data: got %h expected %h", resp_data, word(1)); end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 8; i++) begin
            tick();
            req_valid = 2'b10; req_addr[23:12] = 12'(i * 8); resp_ready = 2'b11;
            #2;
            total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL stream_grant[%0d]: got %b expected 10", i, req_ready); end
            if (i > 0) begin
                total++; if (resp_valid !== 2'b10) begin bad++; $display("FAIL stream_resp_valid[%0d]: got %b expected 10", i, resp_valid); end
                total++; if (resp_data !== word(i - 1)) begin bad++; $display("FAIL stream_resp_data[%0d]: got %h expected %h", i, resp_data, word(i - 1)); end
            end
        end
        tick();
        req_valid = 2'b00;
        #2;
        total++; if (resp_valid !== 2'b10) begin bad++; $display("FAIL stream_last_valid: got %b expected 10", resp_valid); end
        total++; if (resp_data !== word(7)) begin bad++; $display("FAIL stream_last_data: got %h expected %h", resp_data, word(7)); end
    endtask

    task automatic test_backpressure();
        tick();
        req_valid = 2'b11; req_addr = {12'h020, 12'h018}; resp_ready = 2'b11;
        #2;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL bp_grant0: got %b expected 01", req_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            req_valid = 2'b10; resp_ready = 2'b10;
            #2;
            total++; if (resp_valid !== 2'b01) begin bad++; $display("FAIL bp_hold_valid[%0d]: got %b expected 01", i, resp_valid); end
            total++; if (resp_data !== word(3)) begin bad++; $display("FAIL bp_hold_data[%0d]: got %h expected %h", i, resp_data, word(3)); end
            total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL bp_hold_no_grant[%0d]: got %b expected 00", i, req_ready); end
        end
        tick();
        resp_ready = 2'b01;
        #2;
        total++; if (resp_data !== word(3)) begin bad++; $display("FAIL bp_accept_data: got %h expected %h", resp_data, word(3)); end
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL bp_accept_grant: got %b expected 10", req_ready); end
        total++; if (rom_addr !== 12'h020) begin bad++; $display("FAIL bp_accept_addr: got %h expected 020", rom_addr); end
        tick();
        req_valid = 2'b00; resp_ready = 2'b11;
        #2;
        total++; if (resp_valid !== 2'b10) begin bad++; $display("FAIL bp_req1_valid: got %b expected 10", resp_valid); end
        total++; if (resp_data !== word(4)) begin bad++; $display("FAIL bp_req1_data: got %h expected %h", resp_data, word(4)); end
    endtask

    task automatic test_nonowner_ready();
        tick();
        req_valid = 2'b01; req_addr = {12'h038, 12'h030}; resp_ready = 2'b11;
        #2;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL nonowner_grant0: got %b expected 01", req_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            req_valid = 2'b10; resp_ready = 2'b10;
            #2;
            total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL nonowner_no_grant[%0d]: got %b expected 00", i, req_ready); end
            total++; if (resp_valid !== 2'b01) begin bad++; $display("FAIL nonowner_valid[%0d]: got %b expected 01", i, resp_valid); end
            total++; if (resp_data !== word(6)) begin bad++; $display("FAIL nonowner_data[%0d]: got %h expected %h", i, resp_data, word(6)); end
            total++; if (rom_addr !== 12'h030) begin bad++; $display("FAIL nonowner_addr[%0d]: got %h expected 030", i, rom_addr); end
        end
        tick();
        resp_ready = 2'b11;
        #2;
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL nonowner_accept_grant: got %b expected 10", req_ready); end
        tick();
        req_valid = 2'b00;
        #2;
        total++; if (resp_valid !== 2'b10) begin bad++; $display("FAIL nonowner_req1_valid: got %b expected 10", resp_valid); end
        total++; if (resp_data !== word(7)) begin bad++; $display("FAIL nonowner_req1_data: got %h expected %h", resp_data, word(7)); end
    endtask

    task automatic test_reset_midop();
        tick();
        req_valid = 2'b11; req_addr = {12'h008, 12'h028}; resp_ready = 2'b11;
        #2;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL midrst_grant0: got %b expected 01", req_ready); end
        tick();
        rst = 1'b1; req_valid = 2'b00;
        tick();
        rst = 1'b0;
        #2;
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL midrst_resp_valid: got %b expected 00", resp_valid); end
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL midrst_req_ready: got %b expected 00", req_ready); end
        total++; if (rom_addr !== 12'h000) begin bad++; $display("FAIL midrst_rom_addr: got %h expected 000", rom_addr); end
        tick();
        req_valid = 2'b11;
        #2;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL midrst_first_grant: got %b expected 01", req_ready); end
        total++; if (rom_addr !== 12'h028) begin bad++; $display("FAIL midrst_first_addr: got %h expected 028", rom_addr); end
        tick();
        req_valid = 2'b00;
        #2;
        total++; if (resp_valid !== 2'b01) begin bad++; $display("FAIL midrst_resp_after: got %b expected 01", resp_valid); end
        total++; if (resp_data !== word(5)) begin bad++; $display("FAIL midrst_data_after: got %h expected %h", resp_data, word(5)); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_streaming();
        test_backpressure();
        test_nonowner_ready();
        test_reset_midop();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares one synchronous single-port ROM (rom_tech instance, 1-cycle read latency) among NREQ requesters with round-robin arbitration.
- Sequences the ROM address and routes the read data back to the granted requester.
- Sits between boot/debug/fetch masters and the on-chip boot ROM.
- Sustains one read per cycle and applies per-requester response backpressure through a hold register.

Parameters:
NREQ, 2, number of requesters (2..8)
abits, 12, byte-address width, identical to ROM abits
log2_dbytes, 3, log2 of ROM data-bus bytes; dbits = 8*2**log2_dbytes

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
i_req_valid  in  NREQ  request valid per requester
i_req_addr  in  NREQ*abits  byte address per requester; requester k occupies bits [k*abits +: abits]
o_req_ready  out  NREQ  one-hot grant; handshake when valid&ready in the same cycle
o_resp_valid  out  NREQ  one-hot response valid
o_resp_data  out  dbits  read data, shared by all requesters, qualified by o_resp_valid
i_resp_ready  in  NREQ  response accept per requester
o_rom_addr  out  abits  to ROM address port
i_rom_data  in  dbits  from ROM data port, valid one cycle after address

Behaviour:
- States:
  - IDLE: no outstanding read.
  - RESP: ROM data for the previous grant is on i_rom_data this cycle.
  - HOLD: data is parked in hold_reg awaiting accept.
- Registers: state, owner (index of the outstanding grant), rr_last (last granted index), hold_reg.
- can_grant = (state==IDLE) | (state==RESP & i_resp_ready[owner]) | (state==HOLD & i_resp_ready[owner]).
- Grant selection (combinational): first k with i_req_valid[k] searching rr_last+1, rr_last+2, ... modulo NREQ.
  - o_req_ready[k]=1 only if can_grant.
  - At most one bit of o_req_ready is set.
  - o_req_ready never depends on i_req_valid of other requesters except through the arbitration itself.
- o_rom_addr:
  - Equals the granted requester's address when a grant fires.
  - Otherwise holds the last driven value.
  - The full byte address is passed; the ROM drops the low log2_dbytes bits.
- On grant of k: owner<=k, rr_last<=k, next state RESP.
- RESP:
  - o_resp_valid[owner]=1, o_resp_data=i_rom_data.
  - If i_resp_ready[owner]: state<=RESP on a new grant, else IDLE.
  - Else: hold_reg<=i_rom_data, state<=HOLD, no grant this cycle.
- HOLD:
  - o_resp_valid[owner]=1, o_resp_data=hold_reg.
  - Stays in HOLD until i_resp_ready[owner].
  - On accept: same transition as RESP-accept, and a new grant is allowed in the accept cycle.
- Latency: grant at cycle T -> response at T+1 (minimum). Throughput is one read per cycle with continuous accept.
- Requester k may be granted on consecutive cycles only if no other requester is valid.
- i_resp_ready of non-owners is ignored.
- Dropping i_req_valid without a handshake is legal; the arbiter just skips that requester.
- Reset values: state=IDLE, rr_last=NREQ-1 (requester 0 highest priority first), owner=0, hold_reg=0, o_rom_addr=0. Resulting outputs: o_req_ready=0, o_resp_valid=0, o_resp_data=0.
- Reset mid-operation: any outstanding RESP/HOLD is discarded. The next cycle shows o_resp_valid=0 with no response delivered.
- Combinational paths: i_resp_ready -> o_req_ready and i_req_valid/i_req_addr -> o_rom_addr are intentional. There is no path from i_rom_data to any ready.

Test Plan:
- Bench ROM image: word i = 64'hA5A5_0000_0000_0000 + i; NREQ=2, abits=12.
- Single request: req0 valid addr 0x010 at T, resp_ready=1 -> o_req_ready=2'b01 at T; o_resp_valid=2'b01, o_resp_data=64'hA5A5_0000_0000_0002 at T+1; IDLE at T+2.
- Contention: req0 addr 0x000 and req1 addr 0x008 both valid continuously, always ready -> grants alternate 0,1,0,1 one per cycle; responses ...0000, ...0001 alternating, no gaps.
- Streaming: req1 alone issues 0x000,0x008,...,0x038 on 8 consecutive cycles -> 8 consecutive responses words 0..7, no bubbles.
- Backpressure: req0 reads 0x018, resp_ready0 low for 3 cycles while req1 valid -> resp_valid=2'b01 data ...0003 held 4 cycles, o_req_ready=0 during HOLD, req1 granted in the accept cycle, its response on the following cycle.
- Reset mid-op: assert rst in the RESP cycle -> next cycle o_resp_valid=0, o_req_ready=0; after release with both valid, req0 granted first.
- Non-owner ready ignored: owner req0 stalled, i_resp_ready=2'b10 -> stays in HOLD, no grant, data unchanged.
